shared_eva_encoder: RTL and testbench
=====================================

# shared_eva_encoder

Inverse of the tile-group shared-address hash: given a destination tile's X/Y coordinates within the tile group and a word offset in that tile's local DMEM, reconstructs the shared EVA word address a core would have issued. Sits on the response/trace side of the vanilla core next to the load-response path and the trace/debug unit. Requests flow through a two-stage valid/ready pipeline. Stripe/group configuration is latched in registers. Malformed requests are flagged and counted.

## Interface
- width_p, 32, shared EVA word-address width (output width)
- x_cord_width_p, 7, X coordinate / tg_dim_x width field width
- y_cord_width_p, 7, Y coordinate / tg_dim_y width field width
- hash_width_p, 4, stripe (hash) field width
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- cfg_v_i  in  1  configuration write strobe
- cfg_ready_o  out  1  configuration accepted this cycle when high with cfg_v_i
- cfg_hash_i  in  hash_width_p  stripe width s
- cfg_tg_dim_x_width_i  in  x_cord_width_p  X field width xw
- cfg_tg_dim_y_width_i  in  y_cord_width_p  Y field width yw
- v_i  in  1  request valid
- ready_o  out  1  request accepted when v_i & ready_o
- x_i  in  x_cord_width_p  tile X within group
- y_i  in  y_cord_width_p  tile Y within group
- addr_i  in  epa_word_addr_width_gp  local word offset (bsg_manycore_pkg)
- v_o  out  1  result valid
- yumi_i  in  1  consumer takes result; legal only when v_o
- shared_eva_o  out  width_p  reconstructed shared EVA word address
- err_o  out  1  result is malformed; shared_eva_o is 0
- err_count_o  out  8  saturating count of malformed results consumed

## Operation
- Config registers s, xw, yw reset to 0. cfg_ready_o = pipeline empty (both stage valids 0). A config write while requests are in flight is refused.
- Stage 1 (S1) registers x_i, y_i, addr_i on handshake. Stage 2 (S2) holds the computed result.
- The encoding is the exact inverse of the forward hash:
  - eva[s-1:0] = addr[s-1:0]
  - eva[s+xw-1:s] = x[xw-1:0]
  - eva[s+xw+yw-1:s+xw] = y[yw-1:0]
  - eva[i+xw+yw] = addr[i] for s ≤ i < epa_word_addr_width_gp and i+xw+yw < width_p
  - all other eva bits are 0
- err is set, and shared_eva_o forced to 0, if any of these holds:
  - s > max_local_offset_width_gp
  - x_i has a nonzero bit at or above xw
  - y_i has a nonzero bit at or above yw
  - any addr bit i ≥ s with i+xw+yw ≥ width_p is nonzero (truncation)
- Zero-width fields (xw=0 or yw=0 or s=0) are legal: that field occupies no bits.
- Round-trip invariant: for any non-error result, applying the forward hash with the same s/xw/yw returns the original x_i, y_i, addr_i.
- err_count_o increments on yumi_i & v_o & err_o and saturates at 255.

## Timing
- Reset (async assert): S1/S2 valids 0, config 0, err_count_o 0. Outputs then read v_o=0, err_o=0, shared_eva_o=0, ready_o=1, cfg_ready_o=1.
- Latency: request accepted in cycle n → v_o=1 in cycle n+2 when not stalled. Throughput is one request per cycle.
- S2 advance = ~v_o | yumi_i. S1 advance into S2 when S1 valid and S2 advance. ready_o = ~S1_v | S2 advance (combinational from yumi_i, no skid).
- A stalled output holds shared_eva_o and err_o stable until yumi_i.
- Simultaneous accept and drain in the same cycle keeps full throughput with no bubble.
- A config change takes effect for requests accepted after the write cycle. cfg_v_i and v_i in the same cycle with an empty pipeline: config is written, and the request is accepted and uses the new config.
- Reset mid-operation drops in-flight requests with no output.

## Test plan
- Config s=2, xw=2, yw=1. Request x=3, y=1, addr=0xA5 → two cycles later v_o=1, shared_eva_o=0x53D, err_o=0.
- Same config, x=4 → err_o=1, shared_eva_o=0. After yumi_i, err_count_o increments by 1. Repeat 300 times → err_count_o saturates at 255.
- Stream 16 back-to-back requests with yumi_i held 1 → 16 consecutive v_o cycles, in order, no bubbles. Then toggle yumi_i 1-0-1 → ready_o drops while both stages are full, and no result is lost or duplicated.
- Assert cfg_v_i while one request is in flight → cfg_ready_o=0 and config is unchanged. It is accepted once the pipeline drains.
- Config s=max_local_offset_width_gp+1 → every result has err_o=1.
- Config s=0, xw=0, yw=0 → shared_eva_o equals addr_i zero-extended.
- Random round-trip: 1000 random legal configs and requests, each result fed to a forward-hash model → recovered x/y/addr match the inputs.
- Assert reset_i while both stages are valid → v_o=0 immediately (async), and no stale result appears after release.

Source files
------------

// File: rtl/shared_eva_encoder_if.sv
// Request/config/result bundle for the shared EVA encoder.
// master drives requests, configuration and yumi; slave is the encoder.
interface shared_eva_encoder_if #(
    parameter int width_p                = 32,
    parameter int x_cord_width_p         = 7,
    parameter int y_cord_width_p         = 7,
    parameter int hash_width_p           = 4,
    parameter int epa_word_addr_width_gp = 16
);
    logic                              cfg_v_i;
    logic                              cfg_ready_o;
    logic [hash_width_p-1:0]           cfg_hash_i;
    logic [x_cord_width_p-1:0]         cfg_tg_dim_x_width_i;
    logic [y_cord_width_p-1:0]         cfg_tg_dim_y_width_i;

    logic                              v_i;
    logic                              ready_o;
    logic [x_cord_width_p-1:0]         x_i;
    logic [y_cord_width_p-1:0]         y_i;
    logic [epa_word_addr_width_gp-1:0] addr_i;

    logic                              v_o;
    logic                              yumi_i;
    logic [width_p-1:0]                shared_eva_o;
    logic                              err_o;
    logic [7:0]                        err_count_o;

    modport master (
        output cfg_v_i, cfg_hash_i, cfg_tg_dim_x_width_i, cfg_tg_dim_y_width_i,
        output v_i, x_i, y_i, addr_i, yumi_i,
        input  cfg_ready_o, ready_o, v_o, shared_eva_o, err_o, err_count_o
    );

    modport slave (
        input  cfg_v_i, cfg_hash_i, cfg_tg_dim_x_width_i, cfg_tg_dim_y_width_i,
        input  v_i, x_i, y_i, addr_i, yumi_i,
        output cfg_ready_o, ready_o, v_o, shared_eva_o, err_o, err_count_o
    );
endinterface

// File: rtl/shared_eva_encoder.sv
// Rebuilds the shared EVA word address from tile X/Y and a local DMEM word offset,
// i.e. the inverse of the tile-group shared-address hash, through a 2-stage valid/ready pipe.
module shared_eva_encoder #(
    parameter int width_p                   = 32,
    parameter int x_cord_width_p            = 7,
    parameter int y_cord_width_p            = 7,
    parameter int hash_width_p              = 4,
    parameter int epa_word_addr_width_gp    = 16,
    parameter int max_local_offset_width_gp = 9
) (
    input logic                 clk_i,
    input logic                 reset_i,
    shared_eva_encoder_if.slave bus
);

    typedef struct packed {
        logic               err;
        logic [width_p-1:0] eva;
    } enc_t;

    // Low stripe bits stay put, X and Y are spliced in above them, and the remaining
    // offset bits are pushed up past the X/Y fields.
    function automatic enc_t encode(
        input logic [x_cord_width_p-1:0]         x,
        input logic [y_cord_width_p-1:0]         y,
        input logic [epa_word_addr_width_gp-1:0] addr,
        input logic [hash_width_p-1:0]           s,
        input logic [x_cord_width_p-1:0]         xw,
        input logic [y_cord_width_p-1:0]         yw
    );
        enc_t                              r;
        logic [epa_word_addr_width_gp-1:0] low;
        logic [epa_word_addr_width_gp-1:0] high;
        logic [width_p-1:0]                eva;
        logic                              trunc;
        int                                sum;

        sum  = int'(s) + int'(xw) + int'(yw);
        low  = addr & ~({epa_word_addr_width_gp{1'b1}} << s);
        high = addr >> s;
        eva  = width_p'(low)
             | (width_p'(x) << s)
             | (width_p'(y) << (int'(s) + int'(xw)))
             | (width_p'(high) << sum);

        // high[j] lands on eva bit j+sum; anything at or beyond width_p is lost.
        if (sum >= width_p) trunc = |high;
        else                trunc = |(high >> (width_p - sum));

        r.err = (int'(s) > max_local_offset_width_gp) | (|(x >> xw)) | (|(y >> yw)) | trunc;
        r.eva = r.err ? '0 : eva;
        return r;
    endfunction

    logic [hash_width_p-1:0]           cfg_s;
    logic [x_cord_width_p-1:0]         cfg_xw;
    logic [y_cord_width_p-1:0]         cfg_yw;
    logic [7:0]                        err_cnt;

    logic                              vld_p1;
    logic [x_cord_width_p-1:0]         x_p1;
    logic [y_cord_width_p-1:0]         y_p1;
    logic [epa_word_addr_width_gp-1:0] addr_p1;

    logic                              vld_p2;
    logic                              err_p2;
    logic [width_p-1:0]                eva_p2;

    logic                              adv_p2;
    logic                              acc_p1;
    logic                              cfg_we;
    enc_t                              enc_p1;

    assign adv_p2          = ~vld_p2 | bus.yumi_i;
    assign bus.ready_o     = ~vld_p1 | adv_p2;
    assign acc_p1          = bus.v_i & bus.ready_o;
    assign bus.cfg_ready_o = ~vld_p1 & ~vld_p2;
    assign cfg_we          = bus.cfg_v_i & bus.cfg_ready_o;
    assign enc_p1          = encode(x_p1, y_p1, addr_p1, cfg_s, cfg_xw, cfg_yw);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            cfg_s   <= '0;
            cfg_xw  <= '0;
            cfg_yw  <= '0;
            err_cnt <= '0;
        end else begin
            if (bus.ready_o) vld_p1 <= bus.v_i;
            if (adv_p2)      vld_p2 <= vld_p1;
            if (cfg_we) begin
                cfg_s  <= bus.cfg_hash_i;
                cfg_xw <= bus.cfg_tg_dim_x_width_i;
                cfg_yw <= bus.cfg_tg_dim_y_width_i;
            end
            if (bus.yumi_i & vld_p2 & err_p2 & (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

    // Stage 1: capture request fields.
    always_ff @(posedge clk_i) begin
        if (acc_p1) begin
            x_p1    <= bus.x_i;
            y_p1    <= bus.y_i;
            addr_p1 <= bus.addr_i;
        end
    end

    // Stage 2: encoded result, held while the consumer stalls.
    always_ff @(posedge clk_i) begin
        if (vld_p1 & adv_p2) begin
            eva_p2 <= enc_p1.eva;
            err_p2 <= enc_p1.err;
        end
    end

    assign bus.v_o          = vld_p2;
    assign bus.shared_eva_o = vld_p2 ? eva_p2 : '0;
    assign bus.err_o        = vld_p2 & err_p2;
    assign bus.err_count_o  = err_cnt;

endmodule

// File: tb/tb_shared_eva_encoder.sv
// Directed-vector bench for shared_eva_encoder, plus a round-trip through a forward-hash model.
module tb_shared_eva_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic yumi_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    shared_eva_encoder_if bus ();

    assign bus.yumi_i = yumi_en & bus.v_o;

    shared_eva_encoder dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Forward shared-address hash: recovers {x, y, addr} from an EVA word address.
    function automatic logic [29:0] fwd_hash(input logic [31:0] eva, input int s, input int xw, input int yw);
        logic [63:0] e;
        logic [63:0] xv;
        logic [63:0] yv;
        logic [63:0] av;
        e  = 64'(eva);
        xv = (e >> s) & ((64'd1 << xw) - 64'd1);
        yv = (e >> (s + xw)) & ((64'd1 << yw) - 64'd1);
        av = (e & ((64'd1 << s) - 64'd1)) | ((e >> (s + xw + yw)) << s);
        return {xv[6:0], yv[6:0], av[15:0]};
    endfunction

    task automatic drive_cfg(input int s, input int xw, input int yw);
        bus.cfg_hash_i           = 4'(s);
        bus.cfg_tg_dim_x_width_i = 7'(xw);
        bus.cfg_tg_dim_y_width_i = 7'(yw);
    endtask

    task automatic drive_req(input int x, input int y, input int addr);
        bus.x_i    = 7'(x);
        bus.y_i    = 7'(y);
        bus.addr_i = 16'(addr);
    endtask

    task automatic write_cfg(input int s, input int xw, input int yw);
        int n;
        drive_cfg(s, xw, yw);
        bus.cfg_v_i = 1'b1;
        #1;
        n = 0;
        while (!bus.cfg_ready_o && n < 20) begin
            cyc();
            n++;
        end
        check("cfg_ready", 64'(bus.cfg_ready_o), 64'd1);
        cyc();
        bus.cfg_v_i = 1'b0;
    endtask

    task automatic send(input int x, input int y, input int addr);
        int n;
        drive_req(x, y, addr);
        bus.v_i = 1'b1;
        #1;
        n = 0;
        while (!bus.ready_o && n < 20) begin
            cyc();
            n++;
        end
        check("req_ready", 64'(bus.ready_o), 64'd1);
        cyc();
        bus.v_i = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [31:0] exp_eva, input logic exp_err);
        int n;
        n = 0;
        while (!bus.v_o && n < 10) begin
            cyc();
            n++;
        end
        check({tag, "_v"}, 64'(bus.v_o), 64'd1);
        check({tag, "_eva"}, 64'(bus.shared_eva_o), 64'(exp_eva));
        check({tag, "_err"}, 64'(bus.err_o), 64'(exp_err));
        yumi_en = 1'b1;
        cyc();
        yumi_en = 1'b0;
    endtask

    initial begin
        bus.cfg_v_i = 1'b0;
        bus.v_i     = 1'b0;
        drive_cfg(0, 0, 0);
        drive_req(0, 0, 0);

        // Reset state
        repeat (2) cyc();
        check("rst_v_o", 64'(bus.v_o), 64'd0);
        check("rst_err_o", 64'(bus.err_o), 64'd0);
        check("rst_eva", 64'(bus.shared_eva_o), 64'd0);
        check("rst_ready", 64'(bus.ready_o), 64'd1);
        check("rst_cfg_ready", 64'(bus.cfg_ready_o), 64'd1);
        check("rst_err_cnt", 64'(bus.err_count_o), 64'd0);
        rst = 1'b0;
        cyc();

        // Basic vector and two-cycle latency
        write_cfg(2, 2, 1);
        drive_req(3, 1, 'hA5);
        bus.v_i = 1'b1;
        cyc();
        bus.v_i = 1'b0;
        check("lat_n1_v", 64'(bus.v_o), 64'd0);
        cyc();
        check("lat_n2_v", 64'(bus.v_o), 64'd1);
        check("basic_eva", 64'(bus.shared_eva_o), 64'h53D);
        check("basic_err", 64'(bus.err_o), 64'd0);
        yumi_en = 1'b1;
        cyc();
        yumi_en = 1'b0;
        check("basic_drained", 64'(bus.v_o), 64'd0);

        // Field overflow errors and saturating counter
        send(4, 1, 'hA5);
        get_result("x_over", 32'h0, 1'b1);
        check("cnt_1", 64'(bus.err_count_o), 64'd1);
        send(0, 2, 0);
        get_result("y_over", 32'h0, 1'b1);
        check("cnt_2", 64'(bus.err_count_o), 64'd2);
        yumi_en = 1'b1;
        drive_req(4, 0, 0);
        bus.v_i = 1'b1;
        repeat (252) cyc();
        bus.v_i = 1'b0;
        repeat (3) cyc();
        check("cnt_254", 64'(bus.err_count_o), 64'd254);
        bus.v_i = 1'b1;
        repeat (50) cyc();
        bus.v_i = 1'b0;
        repeat (3) cyc();
        yumi_en = 1'b0;
        check("cnt_sat", 64'(bus.err_count_o), 64'd255);

        // 16 back-to-back requests, consumer always ready
        yumi_en = 1'b1;
        for (int c = 0; c < 18; c++) begin
            if (c < 16) begin
                drive_req(c & 3, (c >> 2) & 1, c * 37 + 1);
                bus.v_i = 1'b1;
            end else begin
                bus.v_i = 1'b0;
            end
            if (c >= 2) begin
                check("strm_v", 64'(bus.v_o), 64'd1);
                check("strm_data", 64'({bus.err_o, fwd_hash(bus.shared_eva_o, 2, 2, 1)}),
                      64'({1'b0, 7'((c - 2) & 3), 7'(((c - 2) >> 2) & 1), 16'((c - 2) * 37 + 1)}));
            end
            cyc();
        end
        yumi_en = 1'b0;
        check("strm_no_extra", 64'(bus.v_o), 64'd0);

        // Backpressure: yumi 1-0-1 with both stages full
        drive_req(1, 1, 'h4); bus.v_i = 1'b1; cyc();
        drive_req(2, 0, 'h7); cyc();
        drive_req(3, 1, 'h0); #1;
        check("bp_ready_full", 64'(bus.ready_o), 64'd0);
        check("bp_a", 64'(bus.shared_eva_o), 64'h34);
        cyc();
        yumi_en = 1'b1; #1;
        check("bp_ready_yumi", 64'(bus.ready_o), 64'd1);
        cyc();
        bus.v_i = 1'b0; yumi_en = 1'b0; #1;
        check("bp_b", 64'(bus.shared_eva_o), 64'h2B);
        check("bp_ready_stall", 64'(bus.ready_o), 64'd0);
        cyc();
        check("bp_b_hold", 64'(bus.shared_eva_o), 64'h2B);
        yumi_en = 1'b1;
        cyc();
        check("bp_c_v", 64'(bus.v_o), 64'd1);
        check("bp_c", 64'(bus.shared_eva_o), 64'h1C);
        cyc();
        yumi_en = 1'b0;
        check("bp_no_dup", 64'(bus.v_o), 64'd0);

        // Config write refused while a request is in flight
        drive_req(1, 0, 'h5); bus.v_i = 1'b1; cyc();
        bus.v_i = 1'b0;
        drive_cfg(0, 0, 0); bus.cfg_v_i = 1'b1; #1;
        check("cfg_busy_s1", 64'(bus.cfg_ready_o), 64'd0);
        cyc();
        check("cfg_busy_s2", 64'(bus.cfg_ready_o), 64'd0);
        check("cfg_old_used", 64'(bus.shared_eva_o), 64'h25);
        yumi_en = 1'b1;
        cyc();
        yumi_en = 1'b0; #1;
        check("cfg_drained", 64'(bus.cfg_ready_o), 64'd1);
        cyc();
        bus.cfg_v_i = 1'b0;
        send(0, 0, 'h1234);
        get_result("cfg_new", 32'h1234, 1'b0);

        // Config and request in the same cycle; zero-width fields
        write_cfg(2, 2, 1);
        drive_cfg(0, 0, 0); bus.cfg_v_i = 1'b1;
        drive_req(0, 0, 'hF0); bus.v_i = 1'b1;
        cyc();
        bus.cfg_v_i = 1'b0; bus.v_i = 1'b0;
        get_result("cfg_same", 32'hF0, 1'b0);
        send(0, 0, 'hFFFF);
        get_result("zw_ffff", 32'hFFFF, 1'b0);
        send(1, 0, 0);
        get_result("zw_x_err", 32'h0, 1'b1);

        // Stripe width limits
        write_cfg(9, 0, 0);
        send(0, 0, 'hFFFF);
        get_result("s_max", 32'hFFFF, 1'b0);
        write_cfg(10, 0, 0);
        send(0, 0, 'h3);
        get_result("s_over_a", 32'h0, 1'b1);
        send(0, 0, 'h0);
        get_result("s_over_b", 32'h0, 1'b1);
        check("cnt_hold_sat", 64'(bus.err_count_o), 64'd255);

        // Upper offset bits pushed past the word
        write_cfg(0, 10, 10);
        send(0, 0, 'h0FFF);
        get_result("trunc_edge", 32'hFFF0_0000, 1'b0);
        send(0, 0, 'h1000);
        get_result("trunc_err", 32'h0, 1'b1);

        // Async reset with both stages valid
        write_cfg(2, 2, 1);
        drive_req(1, 1, 'h4); bus.v_i = 1'b1; cyc();
        drive_req(2, 0, 'h7); cyc();
        bus.v_i = 1'b0;
        check("pre_rst_v", 64'(bus.v_o), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_v_o", 64'(bus.v_o), 64'd0);
        check("arst_ready", 64'(bus.ready_o), 64'd1);
        check("arst_cfg_ready", 64'(bus.cfg_ready_o), 64'd1);
        check("arst_err_cnt", 64'(bus.err_count_o), 64'd0);
        check("arst_eva", 64'(bus.shared_eva_o), 64'd0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("post_rst_quiet", 64'(bus.v_o), 64'd0);
        end
        send(0, 0, 'hF0);
        get_result("post_rst_cfg0", 32'hF0, 1'b0);

        // Random legal configs round-tripped through the forward hash
        yumi_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            int s, xw, yw, x, y, a;
            s  = int'($urandom_range(0, 9));
            xw = int'($urandom_range(0, 7));
            yw = int'($urandom_range(0, 7));
            x  = int'($urandom_range(0, (1 << xw) - 1));
            y  = int'($urandom_range(0, (1 << yw) - 1));
            a  = int'($urandom_range(0, 65535));
            drive_cfg(s, xw, yw); bus.cfg_v_i = 1'b1;
            drive_req(x, y, a);   bus.v_i = 1'b1;
            cyc();
            bus.cfg_v_i = 1'b0; bus.v_i = 1'b0;
            cyc();
            check("rt_v", 64'(bus.v_o), 64'd1);
            check("rt_data", 64'({bus.err_o, fwd_hash(bus.shared_eva_o, s, xw, yw)}),
                  64'({1'b0, 7'(x), 7'(y), 16'(a)}));
            cyc();
        end
        yumi_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
